// File: rtl/morra_controller.sv
// Sequencer/arbiter in front of the MorraCinese game FSM: collects both players' moves, issues them as a pair, captures results.
// Optional move timeout is compiled in with `define MORRA_TIMEOUT_EN.
module morra_controller #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             START,
  input  logic [3:0]       CFG,
  input  logic             P1_VALID,
  input  logic [1:0]       P1_MOVE,
  output logic             P1_READY,
  input  logic             P2_VALID,
  input  logic [1:0]       P2_MOVE,
  output logic             P2_READY,
  output logic             G_INIZIO,
  output logic [1:0]       G_PRIMO,
  output logic [1:0]       G_SECONDO,
  input  logic [1:0]       G_MANCHE,
  input  logic [1:0]       G_PARTITA,
  output logic             RIS_VALID,
  output logic [1:0]       RIS_MANCHE,
  output logic [1:0]       RIS_PARTITA,
  output logic [CNT_W-1:0] N_MANCHE,
  output logic             BUSY,
  output logic             ERR
);

  typedef enum logic [2:0] {
    IDLE,
    CONFIG,
    WAIT,
    ISSUE,
    CAPTURE
  } state_t;

  state_t state, state_next;

  logic       full1, full2;
  logic [1:0] move1, move2;
  logic       xfer1, xfer2;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("morra_controller: TIMEOUT_CYC must be at least 1");
  end

  assign P1_READY = (state == WAIT) && !full1;
  assign P2_READY = (state == WAIT) && !full2;
  assign xfer1    = P1_VALID && P1_READY;
  assign xfer2    = P2_VALID && P2_READY;
  assign BUSY     = (state != IDLE);

`ifdef MORRA_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [TW-1:0] tmo_cnt;
  logic          one_full;
  logic          tmo_hit;
  logic          err_q;

  assign one_full = full1 ^ full2;
  assign tmo_hit  = (state == WAIT) && !START && one_full && !xfer1 && !xfer2 &&
                    (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // Counts how long a lone move has been waiting for its partner.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= tmo_hit;
      if ((state != WAIT) || xfer1 || xfer2 || !one_full || tmo_hit)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  always_ff @(posedge clk or posedge RST) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_next;
  end

  // START outside IDLE/CONFIG aborts whatever game is in flight.
  always_comb begin
    state_next = state;
    G_INIZIO   = 1'b0;
    G_PRIMO    = 2'b00;
    G_SECONDO  = 2'b00;
    case (state)
      IDLE: begin
        if (START)
          state_next = CONFIG;
      end
      CONFIG: begin
        G_INIZIO   = 1'b1;
        G_PRIMO    = CFG[3:2];
        G_SECONDO  = CFG[1:0];
        state_next = WAIT;
      end
      WAIT: begin
        if (START)
          state_next = CONFIG;
        else if ((full1 || xfer1) && (full2 || xfer2))
          state_next = ISSUE;
      end
      ISSUE: begin
        G_PRIMO   = move1;
        G_SECONDO = move2;
        if (START)
          state_next = CONFIG;
        else
          state_next = CAPTURE;
      end
      CAPTURE: begin
        if (START)
          state_next = CONFIG;
        else if (G_PARTITA != 2'b00)
          state_next = IDLE;
        else
          state_next = WAIT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Move slots, result capture and manche counter.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      full1       <= 1'b0;
      full2       <= 1'b0;
      move1       <= 2'b00;
      move2       <= 2'b00;
      RIS_VALID   <= 1'b0;
      RIS_MANCHE  <= 2'b00;
      RIS_PARTITA <= 2'b00;
      N_MANCHE    <= '0;
    end else begin
      RIS_VALID <= 1'b0;
      case (state)
        CONFIG: begin
          full1    <= 1'b0;
          full2    <= 1'b0;
          N_MANCHE <= '0;
        end
        WAIT: begin
          if (START) begin
            full1 <= 1'b0;
            full2 <= 1'b0;
          end else begin
            if (xfer1) begin
              full1 <= 1'b1;
              move1 <= P1_MOVE;
            end
            if (xfer2) begin
              full2 <= 1'b1;
              move2 <= P2_MOVE;
            end
`ifdef MORRA_TIMEOUT_EN
            if (tmo_hit) begin
              full1 <= 1'b0;
              full2 <= 1'b0;
            end
`endif
          end
        end
        ISSUE: begin
          full1 <= 1'b0;
          full2 <= 1'b0;
        end
        CAPTURE: begin
          if (!START) begin
            RIS_MANCHE  <= G_MANCHE;
            RIS_PARTITA <= G_PARTITA;
            RIS_VALID   <= 1'b1;
            if ((G_MANCHE != 2'b00) && (N_MANCHE != {CNT_W{1'b1}}))
              N_MANCHE <= N_MANCHE + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_morra_controller.sv
// Self-checking bench for morra_controller: a game stub answers issues, a transaction-level model predicts results.
// Honours MORRA_TIMEOUT_EN when the macro is defined for the build.
module tb_morra_controller;

  localparam int CNT_W = 2;
  localparam int TCYC  = 4;

  logic             clk = 1'b0;
  logic             RST;
  logic             START;
  logic [3:0]       CFG;
  logic             P1_VALID, P2_VALID;
  logic [1:0]       P1_MOVE, P2_MOVE;
  logic             P1_READY, P2_READY;
  logic             G_INIZIO;
  logic [1:0]       G_PRIMO, G_SECONDO;
  logic [1:0]       G_MANCHE, G_PARTITA;
  logic             RIS_VALID;
  logic [1:0]       RIS_MANCHE, RIS_PARTITA;
  logic [CNT_W-1:0] N_MANCHE;
  logic             BUSY, ERR;

  int checks = 0;
  int errors = 0;

  // reference model state (game as seen from outside)
  int         wins1, wins2, expN;
  logic [1:0] expRisM, expRisP;
  bit         gameOver;

  morra_controller #(.TIMEOUT_CYC(TCYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .RST(RST), .START(START), .CFG(CFG),
    .P1_VALID(P1_VALID), .P1_MOVE(P1_MOVE), .P1_READY(P1_READY),
    .P2_VALID(P2_VALID), .P2_MOVE(P2_MOVE), .P2_READY(P2_READY),
    .G_INIZIO(G_INIZIO), .G_PRIMO(G_PRIMO), .G_SECONDO(G_SECONDO),
    .G_MANCHE(G_MANCHE), .G_PARTITA(G_PARTITA),
    .RIS_VALID(RIS_VALID), .RIS_MANCHE(RIS_MANCHE), .RIS_PARTITA(RIS_PARTITA),
    .N_MANCHE(N_MANCHE), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 clk = ~clk;

  // 01 sasso, 10 carta, 11 forbice; 00 invalid. Result 01 p1 wins, 10 p2 wins, 11 draw.
  function automatic logic [1:0] rpsWinner(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    if (a == b) return 2'b11;
    if ((a == 2'b10 && b == 2'b01) || (a == 2'b11 && b == 2'b10) || (a == 2'b01 && b == 2'b11))
      return 2'b01;
    return 2'b10;
  endfunction

  // Game stub: registered outputs, first player to two wins takes the partita.
  int stubW1, stubW2;
  always @(posedge clk or posedge RST) begin
    logic [1:0] w;
    if (RST) begin
      G_MANCHE <= 2'b00; G_PARTITA <= 2'b00; stubW1 = 0; stubW2 = 0;
    end else if (G_INIZIO) begin
      G_MANCHE <= 2'b00; G_PARTITA <= 2'b00; stubW1 = 0; stubW2 = 0;
    end else if (G_PRIMO != 2'b00 || G_SECONDO != 2'b00) begin
      w = rpsWinner(G_PRIMO, G_SECONDO);
      if (w == 2'b01) stubW1++;
      if (w == 2'b10) stubW2++;
      G_MANCHE  <= w;
      G_PARTITA <= (stubW1 >= 2) ? 2'b01 : (stubW2 >= 2) ? 2'b10 : 2'b00;
    end else begin
      G_MANCHE <= 2'b00; G_PARTITA <= 2'b00;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic startGame(input logic [3:0] cfg);
    START = 1'b1; CFG = cfg;
    @(posedge clk); @(negedge clk);
    START = 1'b0;
    checkOutput("cfg_inizio", G_INIZIO, 1);
    checkOutput("cfg_primo", G_PRIMO, cfg[3:2]);
    checkOutput("cfg_secondo", G_SECONDO, cfg[1:0]);
    checkOutput("cfg_busy", BUSY, 1);
    checkOutput("cfg_ready", {P1_READY, P2_READY}, 0);
    checkOutput("cfg_ris_valid", RIS_VALID, 0);
    CFG = 4'($urandom);
    @(posedge clk); @(negedge clk);
    checkOutput("wait_inizio", {G_INIZIO, G_PRIMO, G_SECONDO}, 0);
    checkOutput("wait_n_manche", N_MANCHE, 0);
    checkOutput("wait_ready", {P1_READY, P2_READY}, 2'b11);
    checkOutput("wait_ris_valid", RIS_VALID, 0);
    checkOutput("ris_held", {RIS_MANCHE, RIS_PARTITA}, {expRisM, expRisP});
    wins1 = 0; wins2 = 0; expN = 0; gameOver = 0;
  endtask

  // One manche starting in WAIT at a negedge; ends at the negedge of the result cycle.
  task automatic applyStimulus(input logic [1:0] m1, input logic [1:0] m2,
                               input int d1, input int d2, input bit abort);
    int cyc = 0;
    bit got1 = 0, got2 = 0;
    logic [1:0] w, p;
    while (!(got1 && got2) && cyc < 50) begin
      checkOutput("p1_ready", P1_READY, !got1);
      checkOutput("p2_ready", P2_READY, !got2);
      checkOutput("wait_err", ERR, 0);
      checkOutput("wait_busy", BUSY, 1);
      P1_VALID = !got1 && cyc >= d1;
      P1_MOVE  = P1_VALID ? m1 : 2'($urandom);
      P2_VALID = !got2 && cyc >= d2;
      P2_MOVE  = P2_VALID ? m2 : 2'($urandom);
      if (P1_VALID && P1_READY) got1 = 1;
      if (P2_VALID && P2_READY) got2 = 1;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    P1_VALID = 1'b0; P2_VALID = 1'b0;
    if (!(got1 && got2)) begin
      checkOutput("accept_bound", 0, 1);
      return;
    end
    checkOutput("issue_moves", {G_INIZIO, G_PRIMO, G_SECONDO}, {1'b0, m1, m2});
    checkOutput("issue_ready", {P1_READY, P2_READY}, 0);
    checkOutput("issue_ris_valid", RIS_VALID, 0);
    @(posedge clk); @(negedge clk);
    checkOutput("capture_ready", {P1_READY, P2_READY}, 0);
    checkOutput("capture_game_in", {G_INIZIO, G_PRIMO, G_SECONDO}, 0);
    checkOutput("capture_busy", BUSY, 1);
    checkOutput("capture_ris_valid", RIS_VALID, 0);
    w = rpsWinner(m1, m2);
    if (abort) begin
      startGame(4'($urandom));
      return;
    end
    @(posedge clk); @(negedge clk);
    if (w != 2'b00 && expN < (1 << CNT_W) - 1) expN++;
    if (w == 2'b01) wins1++;
    if (w == 2'b10) wins2++;
    p = (wins1 >= 2) ? 2'b01 : (wins2 >= 2) ? 2'b10 : 2'b00;
    expRisM = w; expRisP = p;
    checkOutput("ris_valid", RIS_VALID, 1);
    checkOutput("ris_manche", RIS_MANCHE, w);
    checkOutput("ris_partita", RIS_PARTITA, p);
    checkOutput("n_manche", N_MANCHE, expN);
    if (p != 2'b00) begin
      gameOver = 1;
      checkOutput("end_busy", BUSY, 0);
      checkOutput("end_ready", {P1_READY, P2_READY}, 0);
    end else begin
      checkOutput("next_busy", BUSY, 1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST = 1'b1; START = 1'b0; CFG = 4'h0;
    P1_VALID = 1'b0; P2_VALID = 1'b0; P1_MOVE = 2'b00; P2_MOVE = 2'b00;
    wins1 = 0; wins2 = 0; expN = 0; expRisM = 2'b00; expRisP = 2'b00; gameOver = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", {P1_READY, P2_READY, G_INIZIO, G_PRIMO, G_SECONDO, RIS_VALID,
                                  RIS_MANCHE, RIS_PARTITA, N_MANCHE, BUSY, ERR}, 0);
    RST = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready", {P1_READY, P2_READY, BUSY}, 0);

    startGame(4'b0000);
    applyStimulus(2'b10, 2'b01, 5, 9, 0);
    applyStimulus(2'b11, 2'b11, 0, 0, 0);
    applyStimulus(2'b00, 2'b10, 0, 1, 0);

    for (int i = 0; i < 80; i++) begin
      if (gameOver) startGame(4'($urandom));
      applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 11) == 0);
    end

    // lone move with silent partner
    if (gameOver) startGame(4'($urandom));
    else startGame(4'b1001);
    P1_VALID = 1'b1; P1_MOVE = 2'b11;
    @(posedge clk); @(negedge clk);
    P1_VALID = 1'b0;
    for (int i = 1; i <= 6; i++) begin
`ifdef MORRA_TIMEOUT_EN
      checkOutput("tmo_err", ERR, i == 5);
      checkOutput("tmo_p1_ready", P1_READY, i >= 5);
`else
      checkOutput("tmo_err", ERR, 0);
      checkOutput("tmo_p1_ready", P1_READY, 0);
`endif
      checkOutput("tmo_p2_ready", P2_READY, 1);
      @(posedge clk); @(negedge clk);
    end

    // restart from WAIT, then asynchronous reset with slot 1 full
    startGame(4'b0110);
    P1_VALID = 1'b1; P1_MOVE = 2'b01;
    @(posedge clk); @(negedge clk);
    P1_VALID = 1'b0;
    checkOutput("pre_reset_p1_full", {P1_READY, P2_READY}, 2'b01);
    #2 RST = 1'b1;
    #1;
    checkOutput("async_reset_outputs", {P1_READY, P2_READY, G_INIZIO, G_PRIMO, G_SECONDO, RIS_VALID,
                                        RIS_MANCHE, RIS_PARTITA, N_MANCHE, BUSY, ERR}, 0);
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_ready", {P1_READY, P2_READY, BUSY}, 0);
    expRisM = 2'b00; expRisP = 2'b00;
    startGame(4'b0101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morra_controller.md
# morra_controller

Sequencer and arbiter placed in front of the `MorraCinese` game FSM. Collects moves from two independently timed players through valid/ready handshakes, starts a game with a configuration word, and pairs the two latched moves into one single-cycle issue to the game. Captures each manche/partita result and reports it upstream with a one-cycle strobe. Owns every drive of `INIZIO`/`PRIMO`/`SECONDO`; no other block touches the game inputs.

## Interface

**Parameters**
- `TIMEOUT_CYC`, default 255: maximum cycles one player's move may wait for the other's (used only with the timeout feature).
- `CNT_W`, default 5: width of the valid-manche counter.

**Ports**
- `clk`, in, 1: single clock, rising edge.
- `RST`, in, 1: reset, asynchronous, active-high.
- `START`, in, 1: new-game request, sampled per cycle.
- `CFG`, in, 4: game configuration, forwarded on the start cycle.
- `P1_VALID` / `P1_MOVE`, in, 1 / 2: player 1 move offer (01 sasso, 10 carta, 11 forbice).
- `P1_READY`, out, 1: slot 1 empty and accepting.
- `P2_VALID` / `P2_MOVE` / `P2_READY`: same as player 1, for player 2.
- `G_INIZIO`, out, 1: drives game `INIZIO`.
- `G_PRIMO` / `G_SECONDO`, out, 2 / 2: drive game `PRIMO` / `SECONDO`.
- `G_MANCHE` / `G_PARTITA`, in, 2 / 2: from game `MANCHE` / `PARTITA`.
- `RIS_VALID`, out, 1: one-cycle strobe, result fields valid.
- `RIS_MANCHE` / `RIS_PARTITA`, out, 2 / 2: captured results, held until the next capture.
- `N_MANCHE`, out, `CNT_W`: count of valid manches in the current game.
- `BUSY`, out, 1: game in progress.
- `ERR`, out, 1: one-cycle timeout strobe (always 0 when the timeout feature is compiled out).

## Operation

**States:** IDLE, CONFIG, WAIT, ISSUE, CAPTURE.

**IDLE**
- `READY`s low.
- `START` moves to CONFIG.

**CONFIG** (exactly one cycle)
- `G_INIZIO` = 1, `G_PRIMO` = `CFG[3:2]`, `G_SECONDO` = `CFG[1:0]`.
- Clears both slots and `N_MANCHE`.
- Next state: WAIT.

**WAIT**
- `Px_READY` = slot x empty.
- A transfer occurs when `VALID` & `READY`; the move is latched into the slot.
- Transfers on both ports in the same cycle are legal.
- Move 00 is accepted and forwarded unchanged; the game rejects it.
- When both slots are full at a clock edge, next state is ISSUE.

**ISSUE** (one cycle)
- `G_PRIMO` = slot 1, `G_SECONDO` = slot 2, `G_INIZIO` = 0.
- Slots are cleared at the end of the cycle.
- Next state: CAPTURE.

**CAPTURE** (one cycle)
- Registers `G_MANCHE` → `RIS_MANCHE` and `G_PARTITA` → `RIS_PARTITA`; `RIS_VALID` pulses the following cycle.
- `N_MANCHE` += 1 if `G_MANCHE` ≠ 00, saturating at 2^`CNT_W` − 1.
- If `G_PARTITA` ≠ 00, next state is IDLE; otherwise WAIT.

**Game-input defaults:** in every state other than CONFIG and ISSUE, `G_INIZIO`/`G_PRIMO`/`G_SECONDO` = 0.

**Restart:** `START` in WAIT, ISSUE or CAPTURE aborts the current game immediately. Next state is CONFIG; pending slots are dropped; a capture in progress is discarded with no `RIS_VALID`.

**`BUSY`:** 1 in every state except IDLE.

**Reset:** state IDLE. All outputs 0, including `RIS_*`, `N_MANCHE`, `ERR`, `READY`s. Slots empty.

## Timing

- `START` to `G_INIZIO` high: 1 cycle (registered state).
- Second move accepted at edge k → ISSUE during cycle k+1 → `RIS_VALID` during cycle k+3.
- Game outputs are registered; they are sampled the cycle after the issue cycle.
- Throughput: one manche per 3 cycles minimum. `READY` is low during ISSUE and CAPTURE.
- `RIS_*` and `N_MANCHE` hold their values in IDLE until the next CONFIG.

## Configuration

Macro: `MORRA_TIMEOUT_EN`.

**Defined:**
- A counter runs in WAIT while exactly one slot is full.
- When it reaches `TIMEOUT_CYC`: the full slot is cleared, `ERR` pulses for one cycle, and the state stays WAIT.
- The counter clears on any transfer and on leaving WAIT.

**Undefined:**
- No counter.
- `ERR` is tied to 0.
- WAIT may last indefinitely.

## Test plan

1. Reset asserted mid-WAIT with slot 1 full → all outputs 0 and state IDLE on the same edge; `P1_READY` = 0 after release.
2. `START`, `CFG` = 0000 → `G_INIZIO` = 1 for exactly one cycle with `G_PRIMO`/`G_SECONDO` = 00/00; `BUSY` = 1.
3. P1 offers 10 at cycle 5, P2 offers 01 at cycle 9:
   - `P1_READY` drops after cycle 5.
   - `G_PRIMO`/`G_SECONDO` = 10/01 for one cycle.
   - `RIS_MANCHE` = 01 with `RIS_VALID`; `N_MANCHE` = 1.
4. Both players offer in the same cycle (11, 11) → one issue; `RIS_MANCHE` = 11 (draw). A move 00 gives `RIS_MANCHE` = 00 and `N_MANCHE` unchanged.
5. Play manches until the game returns `G_PARTITA` = 10 → `RIS_PARTITA` = 10, `BUSY` = 0, IDLE, `READY`s low. A `START` during CAPTURE produces no `RIS_VALID` and a new CONFIG.
6. With `MORRA_TIMEOUT_EN` and `TIMEOUT_CYC` = 4: P1 offers, P2 silent → `ERR` pulse 4 cycles later, `P1_READY` back to 1. Without the macro: no `ERR`, P1 slot held.
